// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
//   Parametrised issue-handshake ALU. Single-cycle ops (ADD/AND/XOR/SUB/OR)
//   complete one edge after accept. MUL runs through a valid-tagged pipeline
//   and completes MULT_STAGES edges after accept. Only one multiply is in
//   flight at a time; ready drops while it is outstanding.
//
// Parameters
//   WIDTH        operand width in bits (2..32)
//   MULT_STAGES  edges from multiply accept to done (1..8)
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-high reset
//   A, B    in   WIDTH-bit unsigned operands (sampled on accept only)
//   op      in   3-bit opcode (NOP/ADD/AND/XOR/MUL/SUB/OR/illegal)
//   start   in   issue request; accepted when ready is high
//   ready   out  block can accept start this cycle
//   done    out  one-cycle pulse, result valid
//   result  out  2*WIDTH-bit result, held until the next done
//   err     out  one-cycle pulse, illegal opcode accepted
// -----------------------------------------------------------------------------
module alu_pipe #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned MULT_STAGES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           op,
  input  logic                 start,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 err
);

  localparam int unsigned RW = 2 * WIDTH;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_e;

  state_e          state_q;
  state_e          state_d;

  logic            accept_c;
  logic            single_in_c;
  logic            mul_in_c;
  logic            illegal_in_c;
  logic            mul_done_c;
  logic [RW-1:0]   alu_c;
  logic [RW-1:0]   prod_c;
  logic [RW-1:0]   mul_prod_c;

  // Issue handshake: ready is a pure decode of the state register.
  assign ready    = (state_q == IDLE);
  assign accept_c = start & ready;

  // Full-width product of the zero-extended operands.
  assign prod_c = RW'(A) * RW'(B);

  // Single-cycle datapath and accept classification.
  always_comb begin
    alu_c        = '0;
    single_in_c  = 1'b0;
    mul_in_c     = 1'b0;
    illegal_in_c = 1'b0;
    case (op)
      OP_ADD: begin
        alu_c       = RW'(A) + RW'(B);
        single_in_c = accept_c;
      end
      OP_AND: begin
        alu_c       = RW'(A & B);
        single_in_c = accept_c;
      end
      OP_XOR: begin
        alu_c       = RW'(A ^ B);
        single_in_c = accept_c;
      end
      OP_SUB: begin
        alu_c       = RW'(A) - RW'(B);
        single_in_c = accept_c;
      end
      OP_OR: begin
        alu_c       = RW'(A | B);
        single_in_c = accept_c;
      end
      OP_MUL:  mul_in_c     = accept_c;
      OP_ILL:  illegal_in_c = accept_c;
      OP_NOP:  alu_c        = '0;
      default: alu_c        = '0;
    endcase
  end

  // Multiply pipeline. The product is formed at accept and then carried with
  // a valid bit; the output register (result/done) is the final stage.
  if (MULT_STAGES <= 1) begin : g_mul_direct
    assign mul_done_c = mul_in_c;
    assign mul_prod_c = prod_c;
  end else begin : g_mul_pipe
    localparam int unsigned PIPE_DEPTH = MULT_STAGES - 1;

    logic [RW-1:0]         prod_q [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] vld_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_q <= '0;
        for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
          prod_q[i] <= '0;
        end
      end else begin
        vld_q[0] <= mul_in_c;
        if (mul_in_c) begin
          prod_q[0] <= prod_c;
        end
        for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
          vld_q[i]  <= vld_q[i-1];
          prod_q[i] <= prod_q[i-1];
        end
      end
    end

    assign mul_done_c = vld_q[PIPE_DEPTH-1];
    assign mul_prod_c = prod_q[PIPE_DEPTH-1];
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: busy from multiply accept until its final stage completes.
  // A one-stage multiply completes on its accept edge and never goes busy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mul_in_c && !mul_done_c) begin
          state_d = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        if (mul_done_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output registers; result moves only together with done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      done <= single_in_c | mul_done_c;
      err  <= illegal_in_c;
      if (single_in_c) begin
        result <= alu_c;
      end else if (mul_done_c) begin
        result <= mul_prod_c;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
//   Drives two alu_pipe instances (WIDTH=8/MULT_STAGES=3 and
//   WIDTH=16/MULT_STAGES=5) from one clock. Expected outputs come from a
//   behavioural model: plain arithmetic for the op result and an absolute
//   completion cycle for the outstanding multiply.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] ADD  = 3'd1;
  localparam logic [2:0] ANDO = 3'd2;
  localparam logic [2:0] XORO = 3'd3;
  localparam logic [2:0] MUL  = 3'd4;
  localparam logic [2:0] SUB  = 3'd5;
  localparam logic [2:0] ORO  = 3'd6;
  localparam logic [2:0] ILL  = 3'd7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic        rst8, start8, ready8, done8, err8;
  logic [7:0]  a8, b8;
  logic [2:0]  op8;
  logic [15:0] res8;

  // WIDTH=16 instance
  logic        rst16, start16, ready16, done16, err16;
  logic [15:0] a16, b16;
  logic [2:0]  op16;
  logic [31:0] res16;

  alu_pipe #(.WIDTH(8), .MULT_STAGES(3)) dut8 (
    .clk(clk), .reset(rst8), .A(a8), .B(b8), .op(op8), .start(start8),
    .ready(ready8), .done(done8), .result(res8), .err(err8)
  );

  alu_pipe #(.WIDTH(16), .MULT_STAGES(5)) dut16 (
    .clk(clk), .reset(rst16), .A(a16), .B(b16), .op(op16), .start(start16),
    .ready(ready16), .done(done16), .result(res16), .err(err16)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  int          w_of [2] = '{8, 16};
  int          s_of [2] = '{3, 5};

  // Model state per instance
  bit          pend    [2];
  int          due     [2];
  logic [63:0] pval    [2];
  logic [63:0] mres    [2];
  bit          m_ready [2];
  bit          in_rst  [2];

  // Currently driven request per instance
  bit          cur_st  [2];
  logic [2:0]  cur_op  [2];
  logic [31:0] cur_a   [2];
  logic [31:0] cur_b   [2];

  function automatic logic [63:0] ref_alu(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input int w);
    logic [63:0] omask, rmask, x, y, r;
    omask = (64'd1 << w) - 64'd1;
    rmask = (64'd1 << (2 * w)) - 64'd1;
    x = {32'd0, a} & omask;
    y = {32'd0, b} & omask;
    case (o)
      ADD:     r = x + y;
      ANDO:    r = x & y;
      XORO:    r = x ^ y;
      ORO:     r = x | y;
      SUB:     r = x - y;
      MUL:     r = x * y;
      default: r = 64'd0;
    endcase
    return r & rmask;
  endfunction

  task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  task automatic drive(input int d, input bit st, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b);
    cur_st[d] = st;
    cur_op[d] = o;
    cur_a[d]  = a;
    cur_b[d]  = b;
    if (d == 0) begin
      start8 = st; op8 = o; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start16 = st; op16 = o; a16 = a[15:0]; b16 = b[15:0];
    end
  endtask

  task automatic check_outputs(input int d, input bit e_done, input bit e_err, input string ph);
    logic        o_ready, o_done, o_err;
    logic [63:0] o_res;
    if (d == 0) begin
      o_ready = ready8; o_done = done8; o_err = err8; o_res = 64'(res8);
    end else begin
      o_ready = ready16; o_done = done16; o_err = err16; o_res = 64'(res16);
    end
    chk({ph, "_ready"},  d, 64'(o_ready), 64'(m_ready[d]));
    chk({ph, "_done"},   d, 64'(o_done),  64'(e_done));
    chk({ph, "_err"},    d, 64'(o_err),   64'(e_err));
    chk({ph, "_result"}, d, o_res,        mres[d]);
  endtask

  // One clock: decide accepts from the model, advance, then check both DUTs.
  task automatic tick();
    bit acc    [2];
    bit e_done [2];
    bit e_err  [2];
    for (int d = 0; d < 2; d++) begin
      acc[d] = cur_st[d] && m_ready[d] && !in_rst[d];
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      e_done[d] = 1'b0;
      e_err[d]  = 1'b0;
      if (in_rst[d]) begin
        pend[d] = 1'b0;
        mres[d] = 64'd0;
      end else begin
        if (acc[d]) begin
          case (cur_op[d])
            NOP: ;
            ILL: e_err[d] = 1'b1;
            MUL: begin
              pend[d] = 1'b1;
              due[d]  = cyc - 1 + s_of[d];
              pval[d] = ref_alu(MUL, cur_a[d], cur_b[d], w_of[d]);
            end
            default: begin
              e_done[d] = 1'b1;
              mres[d]   = ref_alu(cur_op[d], cur_a[d], cur_b[d], w_of[d]);
            end
          endcase
        end
        if (pend[d] && due[d] == cyc) begin
          e_done[d] = 1'b1;
          mres[d]   = pval[d];
          pend[d]   = 1'b0;
        end
      end
      m_ready[d] = !pend[d];
      check_outputs(d, e_done[d], e_err[d], "cyc");
      drive(d, 1'b0, cur_op[d], cur_a[d], cur_b[d]);
    end
  endtask

  // Assert reset partway through the current cycle and check it takes
  // effect before the next edge; reset is then held across one edge.
  task automatic async_reset(input int d);
    #2;
    if (d == 0) rst8 = 1'b1; else rst16 = 1'b1;
    in_rst[d]  = 1'b1;
    pend[d]    = 1'b0;
    mres[d]    = 64'd0;
    m_ready[d] = 1'b1;
    #1;
    check_outputs(d, 1'b0, 1'b0, "rst_async");
    tick();
    if (d == 0) rst8 = 1'b0; else rst16 = 1'b0;
    in_rst[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      pend[d] = 1'b0; due[d] = 0; pval[d] = 64'd0; mres[d] = 64'd0;
      m_ready[d] = 1'b1; in_rst[d] = 1'b1;
      drive(d, 1'b0, NOP, 32'd0, 32'd0);
    end
    rst8  = 1'b1;
    rst16 = 1'b1;
    tick();
    tick();
    rst8  = 1'b0;
    rst16 = 1'b0;
    in_rst[0] = 1'b0;
    in_rst[1] = 1'b0;
    tick();

    // Back-to-back single-cycle ops, one done per cycle
    drive(0, 1'b1, ADD, 32'hFF, 32'hFF);  tick(); chk("add_ff_ff", 0, 64'(res8), 64'h01FE);
    chk("add_done", 0, 64'(done8), 64'd1);
    drive(0, 1'b1, ANDO, 32'hF0, 32'h3C); tick(); chk("and", 0, 64'(res8), 64'h0030);
    drive(0, 1'b1, XORO, 32'hF0, 32'h3C); tick(); chk("xor", 0, 64'(res8), 64'h00CC);
    drive(0, 1'b1, ORO, 32'hF0, 32'h3C);  tick(); chk("or",  0, 64'(res8), 64'h00FC);
    drive(0, 1'b1, SUB, 32'h00, 32'h01);  tick(); chk("sub_wrap", 0, 64'(res8), 64'hFFFF);
    tick();
    chk("idle_no_done", 0, 64'(done8), 64'd0);

    // Multiply handshake, ignored issue while busy, issue on the done cycle
    drive(0, 1'b1, MUL, 32'hFF, 32'hFF); tick();
    chk("mul_busy1_ready", 0, 64'(ready8), 64'd0);
    drive(0, 1'b1, ADD, 32'h01, 32'h01); tick();
    chk("mul_busy2_ready", 0, 64'(ready8), 64'd0);
    chk("mul_busy2_done",  0, 64'(done8),  64'd0);
    tick();
    chk("mul_done",   0, 64'(done8),  64'd1);
    chk("mul_result", 0, 64'(res8),   64'hFE01);
    chk("mul_ready",  0, 64'(ready8), 64'd1);
    drive(0, 1'b1, ADD, 32'd2, 32'd3); tick();
    chk("add_after_mul", 0, 64'(res8), 64'h0005);

    // Illegal and NOP
    drive(0, 1'b1, ILL, 32'h12, 32'h34); tick();
    chk("ill_err",    0, 64'(err8),  64'd1);
    chk("ill_result", 0, 64'(res8),  64'h0005);
    drive(0, 1'b1, NOP, 32'h12, 32'h34); tick();
    chk("nop_done", 0, 64'(done8), 64'd0);
    chk("nop_err",  0, 64'(err8),  64'd0);

    // Asynchronous reset mid-cycle with a nonzero result held
    async_reset(0);
    tick();

    // Reset during an outstanding multiply aborts it
    drive(0, 1'b1, MUL, 32'h12, 32'h34); tick();
    async_reset(0);
    for (int i = 0; i < 4; i++) tick();
    chk("abort_result", 0, 64'(res8),   64'd0);
    chk("abort_ready",  0, 64'(ready8), 64'd1);

    // Wider instance, deeper multiply
    drive(1, 1'b1, MUL, 32'hFFFF, 32'h0002);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mul16_wait_done", 1, 64'(done16), 64'd0);
    end
    tick();
    chk("mul16_done",   1, 64'(done16), 64'd1);
    chk("mul16_result", 1, 64'(res16),  64'h0001FFFE);

    // Random traffic on both instances
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 2; d++) begin
        drive(d, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom, $urandom);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised successor to the team's 8-bit single/three-cycle ALU. It supports operand width WIDTH and a configurable multiply pipeline depth. Added over the previous generation: SUB and OR operations, a ready/busy issue handshake, and an illegal-op flag. It sits between the stimulus driver and the result monitor in the ALU test harness, one operation in flight per multiply.

Parameters:
WIDTH, 8, operand width in bits (2..32)
MULT_STAGES, 3, cycles from multiply accept to done (1..8)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
A  input  WIDTH  operand A (unsigned)
B  input  WIDTH  operand B (unsigned)
op  input  3  opcode: 000 NOP, 001 ADD, 010 AND, 011 XOR, 100 MUL, 101 SUB, 110 OR, 111 illegal
start  input  1  request issue of op this cycle
ready  output  1  block can accept start this cycle
done  output  1  one-cycle pulse: result valid
result  output  2*WIDTH  registered result, held until next done
err  output  1  one-cycle pulse: illegal op accepted

Behaviour:
- Reset (async assert, sync release): state IDLE, ready=1, done=0, err=0, result=0, all multiply pipeline registers and valid bits = 0.
- Accept = start & ready. When ready=0, start is ignored: no state change, no done, no err.
- FSM states: IDLE and MUL_BUSY.
  - IDLE: ready=1. Accept of op 100 -> MUL_BUSY.
  - Any other accept stays IDLE.
  - MUL_BUSY: ready=0. On the cycle done pulses for the multiply, ready returns to 1 combinationally, so back-to-back issue is possible -> IDLE.
- Single-cycle ops (001, 010, 011, 101, 110): done=1 and result updated on the edge after accept, i.e. latency 1. Consecutive cycles of start give consecutive done pulses.
- MUL: A and B captured at accept. Product A*B (full 2*WIDTH bits) is valid with done=1 exactly MULT_STAGES edges after the accept edge. Intermediate pipeline stages carry a valid bit.
- Width rules (A, B zero-extended to 2*WIDTH):
  - ADD: A+B, carry preserved in bit WIDTH.
  - SUB: (A-B) mod 2^(2*WIDTH); wraps when A<B.
  - AND/XOR/OR: upper WIDTH bits 0.
- NOP accepted: no done, no err, result unchanged.
- op 111 accepted: err=1 next cycle, done=0, result unchanged.
- Operand and op inputs are don't-care except on accept cycles.
- result changes only on cycles where done=1.
- Reset asserted mid-multiply: operation aborted, no done ever emitted for it, outputs return to reset values immediately.
- Max values (WIDTH=8):
  - 0xFF*0xFF = 0xFE01.
  - 0xFF+0xFF = 0x01FE.
  - 0x00-0x01 = 0xFFFF.

Test Plan:
- Reset check: assert reset asynchronously mid-cycle -> ready=1, done=0, err=0, result=0x0000 immediately.
- Single-cycle ops (WIDTH=8), one per cycle back-to-back:
  - ADD 0xFF,0xFF -> 0x01FE
  - AND 0xF0,0x3C -> 0x0030
  - XOR 0xF0,0x3C -> 0x00CC
  - OR 0xF0,0x3C -> 0x00FC
  - SUB 0x00,0x01 -> 0xFFFF
  - Expect one done per cycle, each 1 cycle after its start.
- MUL handshake (MULT_STAGES=3):
  - MUL 0xFF,0xFF at cycle t -> ready=0 during t+1..t+2; done and result=0xFE01 at t+3.
  - start=1 with ADD during the busy window -> ignored.
  - ADD 2,3 issued on the done cycle -> result 0x0005 one cycle later.
- Parametrisation: WIDTH=16, MULT_STAGES=5 -> MUL 0xFFFF,0x0002 gives 0x0001FFFE exactly 5 cycles after accept.
- Illegal/NOP:
  - op 111 -> err pulse one cycle, done=0, result keeps prior value.
  - op 000 with start -> no done, no err.
- Reset mid-multiply: MUL 0x12,0x34, reset at t+1 for one cycle -> no done afterwards, result=0, ready=1 after release.
